mash_ncn: RTL and testbench

Noise-cancellation network that closes the MASH delta-sigma modulator chain. It consumes the 1-bit quantize (carry) outputs of the cascaded error-feedback accumulator stages and recombines them into one multi-bit signed divider-modulus offset per sample. It sits directly downstream of the accumulator cascade and upstream of the fractional-N divider control. The block de-skews the pipelined stage carries, applies (1 − z⁻¹)^(k−1) differencing to stage k, and sums the results into a registered output.

---
 rtl/mash_ncn_pkg.sv | 23 ++
 rtl/mash_ncn_if.sv | 24 ++
 rtl/mash_diff.sv | 30 +++
 rtl/mash_ncn.sv | 107 ++++++++++
 tb/tb_mash_ncn.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/mash_ncn_pkg.sv
// Shared constants for the MASH noise-cancellation network.
// Holds the maximum supported cascade order, the minimum output width for an
// order, and the binomial table (C(n,j)) used by reference models of (1-z^-1)^n.
package mash_pkg;

  // Largest cascade order the network supports.
  localparam int P_ORDER_MAX = 4;

  // Output range for order P is [-(2^(P-1)-1), 2^(P-1)].
  // The positive end, 2^(P-1), needs P+1 bits in two's complement.
  function automatic int min_out_w(input int order);
    return order + 1;
  endfunction

  // Row n holds C(n,0..n), zero padded. These are the tap magnitudes of (1-z^-1)^n.
  localparam int BINOM [0:P_ORDER_MAX-1][0:P_ORDER_MAX-1] = '{
    '{1, 0, 0, 0},
    '{1, 1, 0, 0},
    '{1, 2, 1, 0},
    '{1, 3, 3, 1}
  };

endpackage

// File: rtl/mash_ncn_if.sv
// Sample bus between the accumulator cascade and the noise-cancellation network.
// Ports:  i_valid/i_carry/i_clr go toward the network, and o_valid/o_y come back.
//         With NCN_INT_EN, i_n_int goes in and o_div comes back.
// Optional feature macro: NCN_INT_EN (integer divide value added to the output).
interface mash_ncn_if #(
  parameter int P_ORDER = 3,
  parameter int P_OUT_W = 5
);
  logic                       i_valid;
  logic [P_ORDER-1:0]         i_carry;
  logic                       i_clr;
  logic                       o_valid;
  logic signed [P_OUT_W-1:0]  o_y;
`ifdef NCN_INT_EN
  logic [7:0]                 i_n_int;
  logic [8:0]                 o_div;

  modport master (output i_valid, i_carry, i_clr, i_n_int, input o_valid, o_y, o_div);
  modport slave  (input  i_valid, i_carry, i_clr, i_n_int, output o_valid, o_y, o_div);
`else
  modport master (output i_valid, i_carry, i_clr, input o_valid, o_y);
  modport slave  (input  i_valid, i_carry, i_clr, output o_valid, o_y);
`endif
endinterface

// File: rtl/mash_diff.sv
// One first-difference cell: o_d = i_x[n] - i_x[n-1].
// Latency: o_d is combinational from i_x. The history register updates on valid cycles.
// No backpressure. The history holds when i_valid=0 and is zeroed by i_clr or reset.
// Ports: i_clk, i_rst_n (async low), i_clr (sync), i_valid, i_x (signed), o_d (signed).
module mash_diff #(
  parameter int W = 5
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_clr,
  input  logic                i_valid,
  input  logic signed [W-1:0] i_x,
  output logic signed [W-1:0] o_d
);

  logic signed [W-1:0] x_prev;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      x_prev <= '0;
    end else if (i_clr) begin
      x_prev <= '0;
    end else if (i_valid) begin
      x_prev <= i_x;
    end
  end

  assign o_d = i_x - x_prev;

endmodule

// File: rtl/mash_ncn.sv
// MASH noise-cancellation network. It de-skews the stage carries, applies (1-z^-1)^(k-1) to stage k, and sums the results.
// Latency: one cycle from an i_valid sample to o_valid/o_y. A stage-1 carry lands P_ORDER-1 samples later.
// Backpressure: none. One sample is accepted every cycle. Idle cycles hold all state and drop o_valid.
// Ports: i_clk, i_rst_n (async, active-low), and bus (mash_ncn_if.slave: i_valid, i_carry, i_clr, o_valid, o_y).
// Optional macro NCN_INT_EN adds bus.i_n_int and bus.o_div. o_div is i_n_int + o_y, clamped at 0.
module mash_ncn
  import mash_pkg::*;
#(
  parameter int P_ORDER = 3,
  parameter int P_OUT_W = 5
) (
  input  logic      i_clk,
  input  logic      i_rst_n,
  mash_ncn_if.slave bus
);

  if (P_ORDER < 1 || P_ORDER > P_ORDER_MAX || P_OUT_W < min_out_w(P_ORDER)) begin : g_bad_cfg
    $error("mash_ncn: illegal P_ORDER/P_OUT_W combination");
  end

  // Differenced contribution of each stage, all aligned to one sample index.
  logic signed [P_OUT_W-1:0] d [P_ORDER];
  logic signed [P_OUT_W-1:0] sum;

  for (genvar s = 0; s < P_ORDER; s++) begin : g_stage
    // Stage s+1 arrives s samples late. Delaying it by the rest of the cascade lines every stage up.
    localparam int DEPTH = P_ORDER - 1 - s;

    // chain[0] is the aligned carry. chain[c+1] is that carry after c+1 difference cells.
    logic signed [P_OUT_W-1:0] chain [0:s];

    if (DEPTH == 0) begin : g_nodly
      assign chain[0] = {{(P_OUT_W-1){1'b0}}, bus.i_carry[s]};
    end else begin : g_dly
      logic [DEPTH-1:0] sr;

      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          sr <= '0;
        end else if (bus.i_clr) begin
          sr <= '0;
        end else if (bus.i_valid) begin
          // A shift-and-or form stays legal when DEPTH is 1.
          sr <= (sr << 1) | DEPTH'(bus.i_carry[s]);
        end
      end

      assign chain[0] = {{(P_OUT_W-1){1'b0}}, sr[DEPTH-1]};
    end

    for (genvar c = 0; c < s; c++) begin : g_cell
      mash_diff #(.W(P_OUT_W)) u_diff (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_clr   (bus.i_clr),
        .i_valid (bus.i_valid),
        .i_x     (chain[c]),
        .o_d     (chain[c+1])
      );
    end

    assign d[s] = chain[s];
  end

  // The sum can wrap in intermediate steps without harm. The final value always fits P_OUT_W.
  always_comb begin
    sum = '0;
    for (int k = 0; k < P_ORDER; k++) begin
      sum = sum + d[k];
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      bus.o_y     <= '0;
      bus.o_valid <= 1'b0;
    end else if (bus.i_clr) begin
      bus.o_y     <= '0;
      bus.o_valid <= 1'b0;
    end else if (bus.i_valid) begin
      bus.o_y     <= sum;
      bus.o_valid <= 1'b1;
    end else begin
      bus.o_valid <= 1'b0;
    end
  end

`ifdef NCN_INT_EN
  // 10-bit signed holds 255 + 2^(P_ORDER_MAX-1) and the smallest negative offset.
  logic signed [9:0] div_full;
  logic        [8:0] div_clamped;

  assign div_full    = $signed({2'b00, bus.i_n_int}) + 10'(sum);
  assign div_clamped = div_full[9] ? 9'd0 : div_full[8:0];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      bus.o_div <= '0;
    end else if (bus.i_clr) begin
      bus.o_div <= '0;
    end else if (bus.i_valid) begin
      bus.o_div <= div_clamped;
    end
  end
`endif

endmodule

// File: tb/tb_mash_ncn.sv
// Bench for mash_ncn at P_ORDER=3. Directed vectors use hand-computed outputs.
// A random run is scored against a binomial-tap model built on the input history.
module tb_mash_ncn;
  import mash_pkg::*;

  localparam int P = 3;
  localparam int W = 5;

  logic i_clk   = 1'b0;
  logic i_rst_n = 1'b0;
  always #5 i_clk = ~i_clk;

  mash_ncn_if #(.P_ORDER(P), .P_OUT_W(W)) bus ();

  mash_ncn #(.P_ORDER(P), .P_OUT_W(W)) dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .bus     (bus)
  );

  int total = 0;
  int bad   = 0;
  logic [P-1:0] hist [$];

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Drive one cycle and sample 1 time unit after the rising edge.
  task automatic cyc(input logic v, input logic [P-1:0] c, input logic clr);
    bus.i_valid = v;
    bus.i_carry = c;
    bus.i_clr   = clr;
    @(posedge i_clk);
    #1;
  endtask

  task automatic vec(input string tag, input logic [P-1:0] c, input int y);
    cyc(1'b1, c, 1'b0);
    chk({tag, "_vld"}, int'(bus.o_valid), 1);
    chk(tag, int'(bus.o_y), y);
  endtask

  task automatic gap(input string tag, input int y_hold);
    cyc(1'b0, '0, 1'b0);
    chk({tag, "_vld"}, int'(bus.o_valid), 0);
    chk({tag, "_hold"}, int'(bus.o_y), y_hold);
  endtask

  task automatic clear();
    cyc(1'b0, '0, 1'b1);
  endtask

  // y[n] = sum_k sum_j (-1)^j C(k-1,j) * carry_k[n - (P-k) - j]. Samples before history are zero.
  function automatic int ref_y();
    int n = hist.size() - 1;
    int y = 0;
    for (int k = 1; k <= P; k++) begin
      for (int j = 0; j < k; j++) begin
        int idx = n - (P - k) - j;
        if (idx >= 0 && hist[idx][k-1]) y += ((j % 2) != 0) ? -BINOM[k-1][j] : BINOM[k-1][j];
      end
    end
    return y;
  endfunction

  initial begin
    int y_prev;
    logic v;
    logic [P-1:0] c;
    bus.i_valid = 1'b0;
    bus.i_carry = '0;
    bus.i_clr   = 1'b0;
`ifdef NCN_INT_EN
    bus.i_n_int = 8'd0;
`endif

    // Reset state
    @(posedge i_clk);
    @(posedge i_clk);
    #1;
    chk("rst_vld", int'(bus.o_valid), 0);
    chk("rst_y", int'(bus.o_y), 0);
`ifdef NCN_INT_EN
    chk("rst_div", int'(bus.o_div), 0);
`endif
    i_rst_n = 1'b1;

    // All-zero carries: o_y stays 0, and o_valid follows i_valid by one cycle
    for (int i = 0; i < 10; i++) vec("zeros", 3'b000, 0);
    gap("zeros_end", 0);

    // Stage-3 impulse gives the (1-z^-1)^2 taps
    vec("imp3_0", 3'b100, 1);
    vec("imp3_1", 3'b000, -2);
    vec("imp3_2", 3'b000, 1);
    vec("imp3_3", 3'b000, 0);

    // Stage-1 impulse appears two samples later
    vec("imp1_0", 3'b001, 0);
    vec("imp1_1", 3'b000, 0);
    vec("imp1_2", 3'b000, 1);
    vec("imp1_3", 3'b000, 0);
    vec("imp1_4", 3'b000, 0);

    // Constant 111 with idle gaps matches the gapless sequence 1,0,1,1
    clear();
    vec("tog_0", 3'b111, 1);
    gap("tog_g0", 1);
    vec("tog_1", 3'b111, 0);
    gap("tog_g1", 0);
    vec("tog_2", 3'b111, 1);
    gap("tog_g2", 1);
    vec("tog_3", 3'b111, 1);

    // Clear with a coincident valid drops the sample and all history
    cyc(1'b1, 3'b100, 1'b1);
    chk("clr_vld", int'(bus.o_valid), 0);
    chk("clr_y", int'(bus.o_y), 0);
    vec("clr_post0", 3'b000, 0);
    vec("clr_post1", 3'b000, 0);

    // Positive extreme +4, with the integer offset added
    clear();
    vec("max_0", 3'b101, 1);
    vec("max_1", 3'b010, -2);
`ifdef NCN_INT_EN
    bus.i_n_int = 8'd100;
`endif
    vec("max_2", 3'b100, 4);
`ifdef NCN_INT_EN
    chk("div_104", int'(bus.o_div), 104);
`endif

    // Negative extreme -3, with the clamp to zero
    clear();
    vec("min_0", 3'b010, 0);
    vec("min_1", 3'b100, 2);
`ifdef NCN_INT_EN
    bus.i_n_int = 8'd0;
`endif
    vec("min_2", 3'b000, -3);
`ifdef NCN_INT_EN
    chk("div_clamp", int'(bus.o_div), 0);
`endif

    // Asynchronous reset mid-stream
    clear();
    vec("ar_0", 3'b111, 1);
    vec("ar_1", 3'b111, 0);
    vec("ar_2", 3'b111, 1);
    #2 i_rst_n = 1'b0;
    #1;
    chk("arst_vld", int'(bus.o_valid), 0);
    chk("arst_y", int'(bus.o_y), 0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    vec("arst_post", 3'b000, 0);

    // Random carries with random idle cycles, scored against the model
    clear();
    hist.delete();
    y_prev = int'(bus.o_y);
    for (int i = 0; i < 10000; i++) begin
      v = ($urandom_range(0, 3) != 0);
      c = P'($urandom);
`ifdef NCN_INT_EN
      bus.i_n_int = 8'($urandom);
`endif
      cyc(v, c, 1'b0);
      if (v) begin
        hist.push_back(c);
        chk("rnd_vld", int'(bus.o_valid), 1);
        chk("rnd_y", int'(bus.o_y), ref_y());
`ifdef NCN_INT_EN
        chk("rnd_div", int'(bus.o_div),
            (int'(bus.i_n_int) + ref_y() < 0) ? 0 : int'(bus.i_n_int) + ref_y());
`endif
      end else begin
        chk("rnd_idle_vld", int'(bus.o_valid), 0);
        chk("rnd_idle_y", int'(bus.o_y), y_prev);
      end
      y_prev = int'(bus.o_y);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
